// File: rtl/magic_pkg.sv
// magic_pkg: shared constants and types for the MAGIC crossbar row sequencer.
//   NCELLS / DEPTH : row width and program depth
//   CW / AW / IW   : cell-index, program-address and instruction widths
//   OP_NOT/OP_NOR  : op field encoding
//   state_e        : sequencer FSM states
//   instr_t        : instruction word {op, dst, src_a, src_b}
//   instr_illegal  : detects gates that would read their own output cell
package magic_pkg;

    localparam int NCELLS = 16;
    localparam int DEPTH  = 32;
    localparam int CW     = $clog2(NCELLS);
    localparam int AW     = $clog2(DEPTH);
    localparam int IW     = 1 + 3 * CW;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_NOR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_EVAL,
        S_DONE
    } state_e;

    typedef struct packed {
        logic          op;
        logic [CW-1:0] dst;
        logic [CW-1:0] src_a;
        logic [CW-1:0] src_b;
    } instr_t;

    // A MAGIC gate cannot use its output cell as an input: the init phase
    // would overwrite the operand before evaluation. src_b only matters for NOR.
    function automatic logic instr_illegal(input instr_t i);
        return (i.dst == i.src_a) || ((i.op == OP_NOR) && (i.dst == i.src_b));
    endfunction

endpackage

// File: rtl/magic_prog_mem.sv
// magic_prog_mem: gate program store.
//   clk            : clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : combinational read port
// No reset: the program survives a sequencer reset.
module magic_prog_mem #(
    parameter int DEPTH = 32,
    parameter int IW    = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/magic_sequencer.sv
// magic_sequencer: runs a NOR/NOT gate program on one MAGIC crossbar row,
// two cycles per gate (INIT drives the output cell to 1, EVAL conditionally
// switches it to 0), while keeping a behavioural copy of the row's cells.
//   clk, rst                         : clock, async active-high reset
//   prog_we/prog_addr/prog_data      : program load (accepted only when idle)
//   num_ops, in_vec, start           : run length, initial cells, launch
//   busy, done, err                  : status (done is a 1-cycle pulse, err sticky)
//   cells_out                        : current modelled row state
//   xb_init/xb_eval/xb_op/xb_dst/
//   xb_src_a/xb_src_b                : crossbar drive, zero outside INIT/EVAL
module magic_sequencer
    import magic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [IW-1:0]     prog_data,
    input  logic [AW:0]       num_ops,
    input  logic [NCELLS-1:0] in_vec,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [NCELLS-1:0] cells_out,
    output logic              xb_init,
    output logic              xb_eval,
    output logic [CW-1:0]     xb_dst,
    output logic [CW-1:0]     xb_src_a,
    output logic [CW-1:0]     xb_src_b,
    output logic              xb_op
);

    state_e            state_q, state_d;
    logic [NCELLS-1:0] cells_q, cells_d;
    logic [AW:0]       pc_q, pc_d;
    logic [AW:0]       len_q, len_d;
    logic              err_q, err_d;
    instr_t            instr_q, instr_d;

    logic [AW:0]       pc_inc;
    logic [AW-1:0]     rd_addr;
    logic [IW-1:0]     rd_data;
    logic              drive;

    assign pc_inc = pc_q + (AW+1)'(1);

    // The current gate is held in instr_q, fetched one step ahead: word 0 is
    // read while still idle, so a write to address 0 coinciding with start
    // lands after the fetch and is not seen by that run.
    assign rd_addr = (state_q == S_IDLE) ? '0 : pc_inc[AW-1:0];

    magic_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (prog_we && (state_q == S_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cells_q <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cells_q <= cells_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            err_q   <= err_d;
            instr_q <= instr_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d = state_q;
        cells_d = cells_q;
        pc_d    = pc_q;
        len_d   = len_q;
        err_d   = err_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cells_d = in_vec;
                    len_d   = num_ops;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    instr_d = instr_t'(rd_data);
                    state_d = (num_ops == '0) ? S_DONE : S_INIT;
                end
            end
            S_INIT: begin
                // pc_q[AW] set means pc ran past the end of the program store.
                if (instr_illegal(instr_q) || pc_q[AW]) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cells_d[instr_q.dst] = 1'b1;
                    state_d              = S_EVAL;
                end
            end
            S_EVAL: begin
                // MAGIC only switches the output cell 1 -> 0.
                cells_d[instr_q.dst] = cells_q[instr_q.dst] &
                    ~(cells_q[instr_q.src_a] |
                      ((instr_q.op == OP_NOR) & cells_q[instr_q.src_b]));
                pc_d = pc_inc;
                if (pc_inc == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_INIT;
                    instr_d = instr_t'(rd_data);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = err_q;
        cells_out = cells_q;
        xb_init   = (state_q == S_INIT);
        xb_eval   = (state_q == S_EVAL);
        drive     = xb_init || xb_eval;
        xb_op     = drive ? instr_q.op    : 1'b0;
        xb_dst    = drive ? instr_q.dst   : '0;
        xb_src_a  = drive ? instr_q.src_a : '0;
        xb_src_b  = drive ? instr_q.src_b : '0;
    end

endmodule

// File: tb/tb_magic_sequencer.sv
module tb_magic_sequencer;
    import magic_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [IW-1:0]     prog_data;
    logic [AW:0]       num_ops;
    logic [NCELLS-1:0] in_vec;
    logic              start;
    logic              busy, done, err;
    logic [NCELLS-1:0] cells_out;
    logic              xb_init, xb_eval, xb_op;
    logic [CW-1:0]     xb_dst, xb_src_a, xb_src_b;

    magic_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .num_ops   (num_ops),
        .in_vec    (in_vec),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cells_out (cells_out),
        .xb_init   (xb_init),
        .xb_eval   (xb_eval),
        .xb_dst    (xb_dst),
        .xb_src_a  (xb_src_a),
        .xb_src_b  (xb_src_b),
        .xb_op     (xb_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCELLS-1:0] cells;
        logic              err;
        int                lat;
        int                k;
        string             name;
    } done_exp_t;

    done_exp_t      dq[$];
    logic [IW+1:0]  sq[$];     // {init, eval, op, dst, src_a, src_b}
    instr_t         prog_tb [DEPTH];
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic op, input int d, input int a, input int b);
        instr_t i;
        i.op    = op;
        i.dst   = CW'(d);
        i.src_a = CW'(a);
        i.src_b = CW'(b);
        return i;
    endfunction

    task automatic wr(input int a, input instr_t w);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = w;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        prog_tb[a] = w;
    endtask

    // Computes expected cells/err/latency and strobe sequence, then pulses start.
    // max_str < 1000 marks a run that will be cut short: only that many strobes
    // are expected and no done.
    task automatic launch(input string nm, input logic [NCELLS-1:0] inv, input int n,
                          input int max_str, input logic we, input int wa, input instr_t wd);
        logic [NCELLS-1:0] c;
        logic              e;
        int                lat;
        int                nstr;
        done_exp_t         x;
        c    = inv;
        e    = 1'b0;
        lat  = 2 * n + 1;
        nstr = 0;
        for (int g = 0; g < n; g++) begin
            instr_t i;
            i = prog_tb[g];
            if (nstr < max_str) begin sq.push_back({2'b10, i}); nstr++; end
            if (i.dst == i.src_a || (i.op == OP_NOR && i.dst == i.src_b)) begin
                e   = 1'b1;
                lat = 2 * g + 2;
                break;
            end
            if (nstr < max_str) begin sq.push_back({2'b01, i}); nstr++; end
            c[i.dst] = ~(c[i.src_a] | (i.op & c[i.src_b]));
        end
        x.cells = c;
        x.err   = e;
        x.lat   = lat;
        x.k     = cyc + 1;
        x.name  = nm;
        if (max_str >= 1000) dq.push_back(x);
        in_vec    = inv;
        num_ops   = (AW+1)'(n);
        start     = 1'b1;
        prog_we   = we;
        prog_addr = AW'(wa);
        prog_data = wd;
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        if (we) prog_tb[wa] = wd;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((busy || dq.size() != 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk({nm, " finished in time"}, 32'(t < 300), 32'd1);
        chk({nm, " strobes drained"}, 32'(sq.size()), 32'd0);
    endtask

    // Monitor: pops expected strobes and completions as the DUT presents them.
    always @(negedge clk) begin : monitor
        done_exp_t x;
        if (!rst) begin
            if (xb_init || xb_eval) begin
                if (sq.size() == 0)
                    chk("unexpected strobe", 32'({xb_init, xb_eval}), 32'd0);
                else
                    chk("strobe", 32'({xb_init, xb_eval, xb_op, xb_dst, xb_src_a, xb_src_b}),
                        32'(sq.pop_front()));
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected done", 32'(done), 32'd0);
                end else begin
                    x = dq.pop_front();
                    chk({x.name, " cells"}, 32'(cells_out), 32'(x.cells));
                    chk({x.name, " err"}, 32'(err), 32'(x.err));
                    chk({x.name, " latency"}, 32'(cyc - x.k + 1), 32'(x.lat));
                    chk({x.name, " xb idle at done"},
                        32'({xb_init, xb_eval, xb_op, xb_dst, xb_src_a, xb_src_b}), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        instr_t ha [7];
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        num_ops   = '0;
        in_vec    = '0;
        start     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset outs", 32'({busy, done, err, xb_init, xb_eval, xb_op, xb_dst, xb_src_a, xb_src_b}), 32'd0);
        chk("reset cells", 32'(cells_out), 32'd0);

        // Half adder: a in cell 0, b in cell 1; cell6 = a&b, cell8 = a^b
        ha[0] = mk(OP_NOT, 2, 1, 0);
        ha[1] = mk(OP_NOT, 3, 0, 0);
        ha[2] = mk(OP_NOR, 4, 2, 0);
        ha[3] = mk(OP_NOR, 5, 1, 3);
        ha[4] = mk(OP_NOR, 6, 2, 3);
        ha[5] = mk(OP_NOR, 7, 5, 4);
        ha[6] = mk(OP_NOT, 8, 7, 0);
        for (int g = 0; g < 7; g++) wr(g, ha[g]);
        for (int ab = 0; ab < 4; ab++) begin
            launch("half adder", 16'h8000 | 16'(ab), 7, 1000, 1'b0, 0, '0);
            wait_idle("half adder");
            chk("ha and", 32'(cells_out[6]), 32'((ab == 3) ? 1 : 0));
            chk("ha xor", 32'(cells_out[8]), 32'((ab == 1 || ab == 2) ? 1 : 0));
        end

        // Zero-length run
        launch("zero ops", 16'hA5A5, 0, 1000, 1'b0, 0, '0);
        wait_idle("zero ops");
        chk("zero ops hold", 32'(cells_out), 32'h0000A5A5);

        // Illegal gate at pc 0
        wr(0, mk(OP_NOR, 3, 3, 0));
        launch("illegal", 16'h1234, 1, 1000, 1'b0, 0, '0);
        wait_idle("illegal");
        chk("illegal err sticky", 32'(err), 32'd1);

        // Two-gate strobe trace with start/prog_we pulsed mid-run
        wr(0, mk(OP_NOT, 5, 1, 0));
        wr(1, mk(OP_NOR, 6, 5, 2));
        launch("trace", 16'h0002, 2, 1000, 1'b0, 0, '0);
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = AW'(1);
        prog_data = mk(OP_NOT, 7, 0, 0);
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        wait_idle("trace");
        chk("trace cells", 32'(cells_out), 32'h00000042);
        chk("trace err cleared", 32'(err), 32'd0);

        // start with a coincident write to address 0: run uses the old word
        launch("coincident", 16'h0002, 1, 1000, 1'b1, 0, mk(OP_NOT, 4, 3, 0));
        wait_idle("coincident");
        chk("coincident cells", 32'(cells_out), 32'h00000002);

        // Reset during EVAL of gate 3, then rerun the retained program
        for (int g = 0; g < 7; g++) wr(g, ha[g]);
        launch("reset run", 16'h0003, 7, 5, 1'b0, 0, '0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid-run reset outs", 32'({busy, done, err, xb_init, xb_eval, xb_op, xb_dst, xb_src_a, xb_src_b}), 32'd0);
        chk("mid-run reset cells", 32'(cells_out), 32'd0);
        chk("mid-run reset strobes", 32'(sq.size()), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        launch("rerun", 16'h0003, 7, 1000, 1'b0, 0, '0);
        wait_idle("rerun");
        chk("rerun and", 32'(cells_out[6]), 32'd1);
        chk("rerun xor", 32'(cells_out[8]), 32'd0);

        // Full-depth NOT chain i -> i+1 mod NCELLS
        for (int g = 0; g < DEPTH; g++) wr(g, mk(OP_NOT, (g + 1) % NCELLS, g % NCELLS, 0));
        launch("chain", 16'h0001, DEPTH, 1000, 1'b0, 0, '0);
        wait_idle("chain");
        chk("chain cells", 32'(cells_out), 32'h00005555);

        chk("done queue empty", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
